// File: rtl/digit_serial_subtractor_if.sv
// digit_serial_subtractor_if: start/done request bus and result flags for the digit-serial subtractor
interface digit_serial_subtractor_if #(parameter int BITS = 8);
    logic start;
    logic [BITS-1:0] minuend;
    logic [BITS-1:0] subtrahend;
    logic borrow_in;
    logic busy;
    logic done;
    logic [BITS-1:0] difference;
    logic borrow;
    logic zero;
    logic overflow;
    modport master (
        output start, minuend, subtrahend, borrow_in,
        input busy, done, difference, borrow, zero, overflow
    );
    modport slave (
        input start, minuend, subtrahend, borrow_in,
        output busy, done, difference, borrow, zero, overflow
    );
endinterface

// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor: computes minuend - subtrahend - borrow_in over BITS/DIGIT cycles, LSB digit first
module digit_serial_subtractor #(
    parameter int BITS = 8,
    parameter int DIGIT = 2
) (
    input logic clock,
    input logic reset,
    digit_serial_subtractor_if.slave bus
);
    if (DIGIT < 1 || BITS % DIGIT != 0) begin : g_bad_digit
        $error("digit_serial_subtractor: BITS must be a positive multiple of DIGIT");
    end
    localparam int N = BITS / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [CW-1:0] count;
    logic [BITS-1:0] a, b, acc, next_acc;
    logic borrow_reg, last;
    logic [DIGIT:0] d;
    int base;
    assign base = int'(count) * DIGIT;
    assign d = {1'b0, a[base +: DIGIT]} - {1'b0, b[base +: DIGIT]} - {{DIGIT{1'b0}}, borrow_reg};
    // new digit enters at the MSB so digit 0 ends up at the LSB after N shifts
    assign next_acc = BITS'({d[DIGIT-1:0], acc} >> DIGIT);
    assign last = count == CW'(N - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            a <= '0;
            b <= '0;
            acc <= '0;
            borrow_reg <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.difference <= '0;
            bus.borrow <= 1'b0;
            bus.zero <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == RUN) begin
                acc <= next_acc;
                borrow_reg <= d[DIGIT];
                count <= count + 1'b1;
                if (last) begin
                    state <= DONE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    bus.difference <= next_acc;
                    bus.borrow <= d[DIGIT];
                    bus.zero <= next_acc == '0;
                    bus.overflow <= (a[BITS-1] != b[BITS-1]) && (next_acc[BITS-1] != a[BITS-1]);
                end
            end else if (bus.start) begin
                state <= RUN;
                a <= bus.minuend;
                b <= bus.subtrahend;
                borrow_reg <= bus.borrow_in;
                count <= '0;
                bus.busy <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_digit_serial_subtractor.sv
// tb_digit_serial_subtractor: DIGIT 1/2/4/8 instances share stimulus and are checked against an arithmetic model
module tb_digit_serial_subtractor;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    digit_serial_subtractor_if #(.BITS(8)) b1(), b2(), b4(), b8();
    digit_serial_subtractor_if #(.BITS(16)) w();
    digit_serial_subtractor #(.BITS(8), .DIGIT(1)) u1 (.clock(clk), .reset(rst), .bus(b1));
    digit_serial_subtractor #(.BITS(8), .DIGIT(2)) u2 (.clock(clk), .reset(rst), .bus(b2));
    digit_serial_subtractor #(.BITS(8), .DIGIT(4)) u4 (.clock(clk), .reset(rst), .bus(b4));
    digit_serial_subtractor #(.BITS(8), .DIGIT(8)) u8 (.clock(clk), .reset(rst), .bus(b8));
    digit_serial_subtractor #(.BITS(16), .DIGIT(4)) uw (.clock(clk), .reset(rst), .bus(w));
    typedef struct {
        logic [7:0] a, b;
        logic bi;
        logic [7:0] d;
        logic bo, z, o;
    } vec_t;
    vec_t tbl[5];
    int tests = 0, fails = 0;
    logic dn[4], by[4], br[4], zr[4], ov[4];
    logic [7:0] df[4];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic s, input logic [7:0] a, input logic [7:0] b, input logic bi);
        b1.start = s; b1.minuend = a; b1.subtrahend = b; b1.borrow_in = bi;
        b2.start = s; b2.minuend = a; b2.subtrahend = b; b2.borrow_in = bi;
        b4.start = s; b4.minuend = a; b4.subtrahend = b; b4.borrow_in = bi;
        b8.start = s; b8.minuend = a; b8.subtrahend = b; b8.borrow_in = bi;
    endtask
    task automatic sample();
        dn = '{b1.done, b2.done, b4.done, b8.done};
        by = '{b1.busy, b2.busy, b4.busy, b8.busy};
        df = '{b1.difference, b2.difference, b4.difference, b8.difference};
        br = '{b1.borrow, b2.borrow, b4.borrow, b8.borrow};
        zr = '{b1.zero, b2.zero, b4.zero, b8.zero};
        ov = '{b1.overflow, b2.overflow, b4.overflow, b8.overflow};
    endtask
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         output logic [7:0] d, output logic bo, output logic z, output logic o);
        int r;
        r = int'(a) - int'(b) - int'(bi);
        d = 8'(r);
        bo = r < 0;
        z = d == 8'h00;
        o = (a[7] != b[7]) && (d[7] != a[7]);
    endtask
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] ed, input logic eb, input logic ez, input logic eo);
        int lat[4] = '{0, 0, 0, 0};
        int pulses[4] = '{0, 0, 0, 0};
        int busy_n[4] = '{0, 0, 0, 0};
        int exp_lat[4] = '{8, 4, 2, 1};
        int dig[4] = '{1, 2, 4, 8};
        drive(1'b1, a, b, bi);
        tick();
        drive(1'b0, ~a, ~b, ~bi);
        sample();
        for (int i = 0; i < 4; i++) if (by[i]) busy_n[i]++;
        for (int c = 1; c <= 12; c++) begin
            tick();
            sample();
            for (int i = 0; i < 4; i++) begin
                if (dn[i]) begin
                    pulses[i]++;
                    if (lat[i] == 0) lat[i] = c;
                end
                if (by[i]) busy_n[i]++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s d%0d latency", tag, dig[i]), lat[i], exp_lat[i]);
            chk($sformatf("%s d%0d done pulses", tag, dig[i]), pulses[i], 1);
            chk($sformatf("%s d%0d busy cycles", tag, dig[i]), busy_n[i], exp_lat[i]);
            chk($sformatf("%s d%0d diff", tag, dig[i]), df[i], ed);
            chk($sformatf("%s d%0d borrow", tag, dig[i]), br[i], eb);
            chk($sformatf("%s d%0d zero", tag, dig[i]), zr[i], ez);
            chk($sformatf("%s d%0d overflow", tag, dig[i]), ov[i], eo);
        end
    endtask
    initial begin
        int lat, pulses;
        logic [7:0] a, b, ed;
        logic bi, eb, ez, eo;
        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        w.start = 1'b0; w.minuend = '0; w.subtrahend = '0; w.borrow_in = 1'b0;
        tick();
        tick();
        chk("reset busy", b2.busy, 0);
        chk("reset done", b2.done, 0);
        chk("reset diff", b2.difference, 0);
        chk("reset d1 busy", b1.busy, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].bi, tbl[i].d, tbl[i].bo, tbl[i].z, tbl[i].o);
        // back-to-back accept from DONE, then a start pulse mid-RUN that must be ignored
        drive(1'b1, 8'h05, 8'h03, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        lat = 0;
        for (int c = 0; c < 10 && !b2.done; c++) tick();
        chk("b2b first done", b2.done, 1);
        drive(1'b1, 8'h20, 8'h01, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("b2b accepted busy", b2.busy, 1);
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            drive(c == 1, 8'hFF, 8'h00, 1'b1);
            if (b2.done) begin
                pulses++;
                if (lat == 0) lat = c;
            end
        end
        chk("b2b latency", lat, 4);
        chk("b2b pulses", pulses, 1);
        chk("b2b diff", b2.difference, 8'h1F);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        for (int c = 0; c < 12; c++) tick();
        // reset during the second RUN cycle aborts without a done pulse
        drive(1'b1, 8'hAA, 8'h55, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", b2.busy, 0);
        chk("abort done", b2.done, 0);
        chk("abort diff", b2.difference, 0);
        chk("abort borrow", b2.borrow, 0);
        chk("abort zero", b2.zero, 0);
        chk("abort overflow", b2.overflow, 0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (b2.done) pulses++;
        end
        chk("abort no done", pulses, 0);
        run_op("post-abort", tbl[0].a, tbl[0].b, tbl[0].bi, tbl[0].d, tbl[0].bo, tbl[0].z, tbl[0].o);
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            bi = 1'($urandom);
            model(a, b, bi, ed, eb, ez, eo);
            run_op($sformatf("rand%0d", n), a, b, bi, ed, eb, ez, eo);
        end
        w.start = 1'b1; w.minuend = 16'h1234; w.subtrahend = 16'h1234; w.borrow_in = 1'b0;
        tick();
        w.start = 1'b0; w.minuend = 16'hFFFF; w.subtrahend = 16'h0000;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (w.done && lat == 0) lat = c;
        end
        chk("w16 latency", lat, 4);
        chk("w16 diff", w.difference, 0);
        chk("w16 zero", w.zero, 1);
        chk("w16 borrow", w.borrow, 0);
        chk("w16 overflow", w.overflow, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
